imm_ext_ctrl: RTL and testbench

- Decode-stage immediate-extension controller for the 16-bit pipelined processor.
- Selects one of the extension modes and forms the 16-bit operand: 1-bit zero-extend for set-condition results, 5/8-bit zero-extend, and 5/8/11-bit sign-extend.
- Buffers results in a 2-entry elastic (skid) queue between a valid/ready producer (decoder) and consumer (ID/EX register), so that stalls on either side never drop or duplicate an operand.
- Supports pipeline flush and records illegal mode selects in a sticky error bit.

---
 rtl/imm_ext_ctrl.sv | 117 +++++++++++
 tb/tb_imm_ext_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_ctrl.sv
// Decode-stage immediate extension feeding a 2-entry skid queue toward ID/EX.
// Operands are extended on the input side and popped in order. err is sticky.
module imm_ext_ctrl #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      ext_sel,
    input  logic [15:0]     instr,
    input  logic            cond_in,
    input  logic [TAGW-1:0] tag_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     imm_out,
    output logic [TAGW-1:0] tag_out,
    input  logic            flush,
    output logic            err,
    input  logic            err_clr,
    output logic [1:0]      occupancy
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    function automatic logic [15:0] extend_imm(input logic [2:0]  sel,
                                               input logic [15:0] ins,
                                               input logic        cond);
        logic [15:0] res;
        case (sel)
            3'd0:    res = {15'd0, cond};
            3'd1:    res = {11'd0, ins[4:0]};
            3'd2:    res = {{11{ins[4]}}, ins[4:0]};
            3'd3:    res = {8'd0, ins[7:0]};
            3'd4:    res = {{8{ins[7]}}, ins[7:0]};
            3'd5:    res = {{5{ins[10]}}, ins[10:0]};
            3'd6:    res = 16'h0000;
            default: res = 16'h0000;
        endcase
        return res;
    endfunction

    logic [15:0]     imm_mem_r [0:1];
    logic [TAGW-1:0] tag_mem_r [0:1];
    logic            wr_ptr_r;
    logic            rd_ptr_r;
    logic [1:0]      count_r;
    logic            err_r;

    logic [15:0]     ext_s;
    logic            illegal_s;
    logic            accept_s;
    logic            pop_s;
    logic            in_ready_s;
    logic            out_valid_s;

    // Input-side extension and handshake qualification.
    always_comb begin
        ext_s       = extend_imm(ext_sel, instr, cond_in);
        illegal_s   = (ext_sel == 3'd7);
        in_ready_s  = (count_r < FULL_CNT);
        out_valid_s = (count_r != 2'd0);
        accept_s    = in_valid && in_ready_s;
        pop_s       = out_valid_s && out_ready;
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign occupancy = count_r;
    assign imm_out   = imm_mem_r[rd_ptr_r];
    assign tag_out   = tag_mem_r[rd_ptr_r];
    assign err       = err_r;

    // Queue storage, pointers and occupancy; flush outranks accept and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                imm_mem_r[i] <= 16'h0000;
                tag_mem_r[i] <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (accept_s) begin
                imm_mem_r[wr_ptr_r] <= ext_s;
                tag_mem_r[wr_ptr_r] <= tag_in;
                wr_ptr_r            <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky illegal-select flag; a dropped (flushed) request cannot set it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (accept_s && illegal_s && !flush) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Directed bench for imm_ext_ctrl with a queue-based reference model
// checked every cycle, plus literal checks on the key scenarios.
module tb_imm_ext_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ext_sel;
    logic [15:0] instr;
    logic        cond_in;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] imm_out;
    logic [3:0]  tag_out;
    logic        flush;
    logic        err;
    logic        err_clr;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] imm;
        logic [3:0]  tag;
    } entry_t;

    entry_t model_q[$];
    logic   m_err;

    imm_ext_ctrl #(.DEPTH(2), .TAGW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ext_sel(ext_sel), .instr(instr), .cond_in(cond_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm_out),
        .tag_out(tag_out), .flush(flush), .err(err), .err_clr(err_clr),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Field width and signedness per mode, value reduced arithmetically.
    function automatic logic [15:0] model_ext(input int sel, input logic [15:0] ins, input logic c);
        int width;
        bit sgn;
        int v;
        case (sel)
            0: return c ? 16'd1 : 16'd0;
            1: begin width = 5;  sgn = 1'b0; end
            2: begin width = 5;  sgn = 1'b1; end
            3: begin width = 8;  sgn = 1'b0; end
            4: begin width = 8;  sgn = 1'b1; end
            5: begin width = 11; sgn = 1'b1; end
            default: return 16'd0;
        endcase
        v = int'(ins) % (1 << width);
        if (sgn && v >= (1 << (width - 1))) v = v - (1 << width);
        return 16'(v);
    endfunction

    always @(posedge clk or posedge rst) begin
        bit acc;
        bit pop;
        if (rst) begin
            model_q.delete();
            m_err = 1'b0;
        end else begin
            acc = in_valid && (model_q.size() < 2);
            pop = out_ready && (model_q.size() != 0);
            if (flush) begin
                model_q.delete();
            end else begin
                if (pop) void'(model_q.pop_front());
                if (acc) model_q.push_back({model_ext(int'(ext_sel), instr, cond_in), tag_in});
            end
            if (acc && !flush && ext_sel == 3'd7) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_occ", 32'(occupancy), 32'(model_q.size()));
            check("m_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            check("m_in_ready", 32'(in_ready), 32'(model_q.size() < 2));
            check("m_err", 32'(err), 32'(m_err));
            if (model_q.size() != 0) begin
                check("m_imm", 32'(imm_out), 32'(model_q[0].imm));
                check("m_tag", 32'(tag_out), 32'(model_q[0].tag));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [15:0] ins, input logic c, input logic [3:0] tg);
        in_valid = 1'b1;
        ext_sel  = sel;
        instr    = ins;
        cond_in  = c;
        tag_in   = tg;
    endtask

    logic [2:0]  sw_sel [6] = '{3'd2, 3'd1, 3'd4, 3'd3, 3'd5, 3'd0};
    logic [15:0] sw_exp [6] = '{16'hFFF5, 16'h0015, 16'hFF95, 16'h0095, 16'hFF95, 16'h0001};

    initial begin
        rst = 1'b1; in_valid = 1'b0; ext_sel = 3'd0; instr = 16'h0000; cond_in = 1'b0;
        tag_in = 4'd0; out_ready = 1'b0; flush = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_imm", 32'(imm_out), 32'h0);
        check("rst_tag", 32'(tag_out), 32'h0);
        check("rst_err", 32'(err), 32'd0);
        check("pin_se5", 32'(model_ext(2, 16'h0795, 1'b0)), 32'h0000FFF5);
        check("pin_se11", 32'(model_ext(5, 16'h0795, 1'b0)), 32'h0000FF95);
        rst = 1'b0;

        // Mode sweep with a draining consumer.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(sw_sel[i], 16'h0795, 1'b1, 4'(i));
            check("sweep_no_bypass", 32'(out_valid), 32'd0);
            step();
            in_valid = 1'b0;
            check("sweep_valid", 32'(out_valid), 32'd1);
            check("sweep_imm", 32'(imm_out), 32'(sw_exp[i]));
            check("sweep_tag", 32'(tag_out), 32'(i));
            step();
        end

        // Backpressure, then full-plus-pop.
        out_ready = 1'b0;
        drive(3'd3, 16'h0011, 1'b0, 4'd1); step();
        drive(3'd3, 16'h0022, 1'b0, 4'd2); step();
        drive(3'd3, 16'h0033, 1'b0, 4'd3); step();
        check("bp_occ", 32'(occupancy), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head_tag", 32'(tag_out), 32'd1);
        out_ready = 1'b1;
        check("fp_in_ready", 32'(in_ready), 32'd0);
        step();
        check("fp_occ", 32'(occupancy), 32'd1);
        check("fp_tag2", 32'(tag_out), 32'd2);
        check("fp_in_ready_rise", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("fp_occ_steady", 32'(occupancy), 32'd1);
        check("fp_tag3", 32'(tag_out), 32'd3);
        check("fp_imm3", 32'(imm_out), 32'h0033);
        step();
        check("fp_drained", 32'(out_valid), 32'd0);

        // Flush with a full queue, then with room so the request would be taken.
        out_ready = 1'b0;
        drive(3'd1, 16'h0004, 1'b0, 4'd4); step();
        drive(3'd1, 16'h0005, 1'b0, 4'd5); step();
        check("fl_occ_full", 32'(occupancy), 32'd2);
        drive(3'd1, 16'h0006, 1'b0, 4'd6);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_occ", 32'(occupancy), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        drive(3'd1, 16'h0007, 1'b0, 4'd7); step();
        drive(3'd1, 16'h0008, 1'b0, 4'd8);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl2_occ", 32'(occupancy), 32'd0);
        out_ready = 1'b1;
        step(); step();
        check("fl2_nothing", 32'(out_valid), 32'd0);

        // Illegal select and err set/clear priority.
        drive(3'd7, 16'hFFFF, 1'b1, 4'd9); step();
        in_valid = 1'b0;
        check("il_imm", 32'(imm_out), 32'h0000);
        check("il_err", 32'(err), 32'd1);
        step();
        drive(3'd7, 16'hFFFF, 1'b1, 4'd9);
        err_clr = 1'b1;
        step();
        in_valid = 1'b0;
        check("il_set_wins", 32'(err), 32'd1);
        step();
        err_clr = 1'b0;
        check("il_cleared", 32'(err), 32'd0);

        // Illegal select that is held off must not set err.
        out_ready = 1'b0;
        drive(3'd4, 16'h0080, 1'b0, 4'd10); step();
        drive(3'd5, 16'h0400, 1'b0, 4'd11); step();
        drive(3'd7, 16'h0000, 1'b0, 4'd12); step();
        check("il_held_err", 32'(err), 32'd0);
        check("il_held_imm", 32'(imm_out), 32'hFF80);
        out_ready = 1'b1; step();
        out_ready = 1'b0; step();
        in_valid = 1'b0;
        check("ar_pre_occ", 32'(occupancy), 32'd2);
        check("ar_pre_err", 32'(err), 32'd1);
        check("ar_pre_tag", 32'(tag_out), 32'd11);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_occ", 32'(occupancy), 32'd0);
        check("ar_err", 32'(err), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b0;
        step(); step();
        check("post_idle", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
